// File: rtl/frogger_pkg.sv
// Shared frogger definitions: screen geometry, VGA port widths, arbiter state encoding.
package frogger_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Reusable by any shared-resource arbiter.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          valid
);

   int unsigned idx;

   // Scan from ptr upward; the first hit wins and later hits are ignored.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr) + i) % N;
         if (!valid && req[idx[IW-1:0]]) begin
            valid = 1'b1;
            grant = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter plot port among N_REQ sprite
// requesters. Each job is a 2^SIDE_LOG2 square box fill drawn in raster order.
// Optional macro PLOT_ARBITER_CLIP_EN suppresses plot for off-screen pixels.
module plot_arbiter
   import frogger_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int SIDE_LOG2 = 2
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [N_REQ-1:0]          req,
   input  logic [8*N_REQ-1:0]        req_x,
   input  logic [7*N_REQ-1:0]        req_y,
   input  logic [3*N_REQ-1:0]        req_colour,
   output logic [N_REQ-1:0]          ack,
   output logic [N_REQ-1:0]          done,
   output logic [X_W-1:0]            x_out,
   output logic [Y_W-1:0]            y_out,
   output logic [COLOUR_W-1:0]       colour_out,
   output logic                      plot,
   output logic                      busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = 2 * SIDE_LOG2;
   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   arb_state_t           state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     gid;
   logic [CNT_W-1:0]     cnt;
   logic [X_W-1:0]       bx;
   logic [Y_W-1:0]       by;
   logic [COLOUR_W-1:0]  col;

   logic [PTR_W-1:0]     pick_idx;
   logic                 pick_valid;

   logic [X_W-1:0]       sel_x;
   logic [Y_W-1:0]       sel_y;
   logic [COLOUR_W-1:0]  sel_col;
   logic [X_W-1:0]       src_x;
   logic [Y_W-1:0]       src_y;
   logic [CNT_W-1:0]     nxt_cnt;
   logic [SIDE_LOG2-1:0] off_x;
   logic [SIDE_LOG2-1:0] off_y;
   logic [X_W-1:0]       pix_x;
   logic [Y_W-1:0]       pix_y;
   logic                 pix_on;
`ifdef PLOT_ARBITER_CLIP_EN
   logic [X_W:0]         sum_x;
   logic [Y_W:0]         sum_y;
`endif

   rr_pick #(
      .N  (N_REQ),
      .IW (PTR_W)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick_idx),
      .valid (pick_valid)
   );

   // Next pixel to present: in IDLE it is pixel 0 of the job being granted
   // (taken straight from the request bus), in DRAW it is pixel cnt+1 of the
   // latched job. Registering this keeps all VGA-side outputs flop-driven.
   always_comb begin
      sel_x   = req_x[int'(pick_idx)*X_W +: X_W];
      sel_y   = req_y[int'(pick_idx)*Y_W +: Y_W];
      sel_col = req_colour[int'(pick_idx)*COLOUR_W +: COLOUR_W];
      src_x   = (state == ST_IDLE) ? sel_x : bx;
      src_y   = (state == ST_IDLE) ? sel_y : by;
      nxt_cnt = (state == ST_IDLE) ? '0 : cnt + 1'b1;
      off_x   = nxt_cnt[SIDE_LOG2-1:0];
      off_y   = nxt_cnt[CNT_W-1:SIDE_LOG2];
`ifdef PLOT_ARBITER_CLIP_EN
      sum_x   = {1'b0, src_x} + (X_W+1)'(off_x);
      sum_y   = {1'b0, src_y} + (Y_W+1)'(off_y);
      pix_x   = sum_x[X_W-1:0];
      pix_y   = sum_y[Y_W-1:0];
      pix_on  = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
`else
      pix_x   = src_x + X_W'(off_x);
      pix_y   = src_y + Y_W'(off_y);
      pix_on  = 1'b1;
`endif
   end

   // Arbitration FSM with registered ack/done/pixel outputs.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         gid        <= '0;
         cnt        <= '0;
         bx         <= '0;
         by         <= '0;
         col        <= '0;
         ack        <= '0;
         done       <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= '0;
      end else begin
         ack  <= '0;
         done <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  bx            <= sel_x;
                  by            <= sel_y;
                  col           <= sel_col;
                  gid           <= pick_idx;
                  cnt           <= '0;
                  state         <= ST_DRAW;
                  busy          <= 1'b1;
                  ack[pick_idx] <= 1'b1;
                  plot          <= pix_on;
                  x_out         <= pix_x;
                  y_out         <= pix_y;
                  colour_out    <= sel_col;
               end
            end
            ST_DRAW: begin
               if (cnt == CNT_LAST) begin
                  state      <= ST_DONE;
                  done[gid]  <= 1'b1;
                  plot       <= 1'b0;
                  x_out      <= '0;
                  y_out      <= '0;
                  colour_out <= '0;
               end else begin
                  cnt        <= nxt_cnt;
                  plot       <= pix_on;
                  x_out      <= pix_x;
                  y_out      <= pix_y;
                  colour_out <= col;
               end
            end
            ST_DONE: begin
               rr_ptr <= (gid == PTR_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
               state  <= ST_IDLE;
               busy   <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter (default parameters: 4 requesters, 4x4 box).
// Expectations follow PLOT_ARBITER_CLIP_EN when the macro is defined.
module tb_plot_arbiter;

   logic        clock;
   logic        resetn;
   logic [3:0]  req;
   logic [31:0] req_x;
   logic [27:0] req_y;
   logic [11:0] req_colour;
   logic [3:0]  ack;
   logic [3:0]  done;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [2:0]  colour_out;
   logic        plot;
   logic        busy;

   logic [7:0]  rx [4];
   logic [6:0]  ry [4];
   logic [2:0]  rc [4];

   int total;
   int bad;

   assign req_x      = {rx[3], rx[2], rx[1], rx[0]};
   assign req_y      = {ry[3], ry[2], ry[1], ry[0]};
   assign req_colour = {rc[3], rc[2], rc[1], rc[0]};

   plot_arbiter #(
      .N_REQ     (4),
      .SIDE_LOG2 (2)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .ack        (ack),
      .done       (done),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out),
      .plot       (plot),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Checks DRAW cycles k0..k1-1 of job g (origin x,y, colour c), ticking after each.
   task automatic draw_chk(input int g, input int x, input int y, input int c,
                           input int k0, input int k1);
      int px, py, pl;
      for (int k = k0; k < k1; k++) begin
         px = x + (k % 4);
         py = y + (k / 4);
`ifdef PLOT_ARBITER_CLIP_EN
         pl = (px < 160 && py < 120) ? 1 : 0;
`else
         pl = 1;
`endif
         chk("ack",    ack,        (k == 0) ? (1 << g) : 0);
         chk("done",   done,       0);
         chk("plot",   plot,       pl);
         chk("x_out",  x_out,      px % 256);
         chk("y_out",  y_out,      py % 128);
         chk("colour", colour_out, c);
         chk("busy",   busy,       1);
         tick();
      end
   endtask

   // DONE cycle of job g.
   task automatic done_chk(input int g);
      chk("done_pulse", done,  1 << g);
      chk("done_ack",   ack,   0);
      chk("done_plot",  plot,  0);
      chk("done_x",     x_out, 0);
      chk("done_busy",  busy,  1);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_plot"}, plot, 0);
      chk({tag, "_ack"},  ack,  0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      req    = '0;
      for (int i = 0; i < 4; i++) begin
         rx[i] = '0;
         ry[i] = '0;
         rc[i] = '0;
      end

      // Reset state
      tick();
      tick();
      chk("rst_ack",    ack,        0);
      chk("rst_done",   done,       0);
      chk("rst_plot",   plot,       0);
      chk("rst_busy",   busy,       0);
      chk("rst_x",      x_out,      0);
      chk("rst_y",      y_out,      0);
      chk("rst_colour", colour_out, 0);
      resetn = 1'b1;
      tick();
      idle_chk("idle0");

      // Single job on requester 0
      rx[0] = 8'd10; ry[0] = 7'd20; rc[0] = 3'b100;
      req = 4'b0001;
      tick();
      draw_chk(0, 10, 20, 4, 0, 16);
      done_chk(0);
      req = 4'b0000;
      tick();
      idle_chk("single_end");

      // Contention from reset: grants 0,1,2,3,0
      for (int i = 0; i < 4; i++) begin
         rx[i] = 8'(20 * i + 5);
         ry[i] = 7'(10 * i + 3);
         rc[i] = 3'(i + 1);
      end
      req    = 4'b1111;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      idle_chk("cont_rst");
      tick();
      for (int j = 0; j < 5; j++) begin
         draw_chk(j % 4, 20 * (j % 4) + 5, 10 * (j % 4) + 3, (j % 4) + 1, 0, 16);
         done_chk(j % 4);
         tick();
         idle_chk("cont_gap");
         tick();
      end
      // Leaves a sixth grant (requester 1) just issued; let it finish.
      req = 4'b0000;
      draw_chk(1, 25, 13, 2, 0, 16);
      done_chk(1);
      tick();
      tick();
      idle_chk("cont_end");

      // Fairness: rr_ptr=2. Grant 2, then 1 and 3 together -> 3 first.
      rx[2] = 8'd40; ry[2] = 7'd50; rc[2] = 3'd5;
      req = 4'b0100;
      tick();
      req = 4'b1010;
      draw_chk(2, 40, 50, 5, 0, 16);
      done_chk(2);
      tick();
      tick();
      draw_chk(3, 65, 33, 4, 0, 16);
      req = 4'b0010;
      done_chk(3);
      tick();
      tick();
      draw_chk(1, 25, 13, 2, 0, 16);
      req = 4'b0000;
      done_chk(1);
      tick();
      tick();
      idle_chk("fair_end");

      // Withdrawal: req[1] pulsed for one cycle while job 0 draws (rr_ptr=2).
      rx[0] = 8'd7; ry[0] = 7'd9; rc[0] = 3'd6;
      req = 4'b0001;
      tick();
      req = 4'b0010;
      draw_chk(0, 7, 9, 6, 0, 1);
      req = 4'b0000;
      draw_chk(0, 7, 9, 6, 1, 16);
      done_chk(0);
      tick();
      tick();
      idle_chk("wd_idle1");
      tick();
      idle_chk("wd_idle2");

      // Screen edge: origin (158,118); data changed after ack has no effect.
      rx[2] = 8'd158; ry[2] = 7'd118; rc[2] = 3'd7;
      req = 4'b0100;
      tick();
      req   = 4'b0000;
      rx[2] = 8'd0; ry[2] = 7'd0; rc[2] = 3'd1;
      draw_chk(2, 158, 118, 7, 0, 16);
      done_chk(2);
      tick();
      tick();

      // Wrap past 255/127: origin (254,126).
      rx[3] = 8'd254; ry[3] = 7'd126; rc[3] = 3'd3;
      req = 4'b1000;
      tick();
      req = 4'b0000;
      draw_chk(3, 254, 126, 3, 0, 16);
      done_chk(3);
      tick();
      tick();
      idle_chk("wrap_end");

      // Reset on the 7th DRAW cycle of job 2 abandons it.
      rx[2] = 8'd50; ry[2] = 7'd60; rc[2] = 3'd2;
      req = 4'b0100;
      tick();
      draw_chk(2, 50, 60, 2, 0, 6);
      chk("mid_plot", plot, 1);
      resetn = 1'b0;
      req    = 4'b0000;
      tick();
      resetn = 1'b1;
      idle_chk("mid_rst");
      chk("mid_x", x_out, 0);
      tick();
      idle_chk("mid_after");
      // rr_ptr back at 0: with 1 and 2 both asking, 1 wins.
      rx[1] = 8'd30; ry[1] = 7'd31; rc[1] = 3'd1;
      req = 4'b0110;
      tick();
      req = 4'b0100;
      draw_chk(1, 30, 31, 1, 0, 16);
      done_chk(1);
      tick();
      tick();
      draw_chk(2, 50, 60, 2, 0, 16);
      req = 4'b0000;
      done_chk(2);
      tick();
      tick();
      idle_chk("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
